fft_twiddle_gen: RTL and testbench

//  Twiddle-factor source for one R2^2SDF FFT stage; drives w_re/w_im of the stage's

---
 rtl/fft_twiddle_gen_if.sv | 20 ++
 rtl/fft_twiddle_gen.sv | 138 +++++++++++++
 tb/tb_fft_twiddle_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_gen_if.sv
// Sample-stream handshake and twiddle outputs between one FFT stage and its twiddle source.
interface fft_twiddle_gen_if #(
  parameter int TWIDDLE_WIDTH = 10
);
  logic                            ce_i;
  logic                            sync_i;
  logic signed [TWIDDLE_WIDTH-1:0] w_re_o;
  logic signed [TWIDDLE_WIDTH-1:0] w_im_o;
  logic                            valid_o;

  modport master (
    output ce_i, sync_i,
    input  w_re_o, w_im_o, valid_o
  );

  modport slave (
    input  ce_i, sync_i,
    output w_re_o, w_im_o, valid_o
  );
endinterface

// File: rtl/fft_twiddle_gen.sv
// Twiddle source for one R2^2SDF stage: sample counter -> DIF exponent -> quarter-wave
// cosine ROM lookup -> quadrant sign fix-up, three pipeline registers, W = cos - j*sin.
module fft_twiddle_gen #(
  parameter int TWIDDLE_WIDTH = 10,
  parameter int FFT_N         = 1024,
  parameter int NLOG2         = 10,
  parameter int STAGE         = 0,
  parameter     TWIDDLE_FILE  = "cos.hex"
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fft_twiddle_gen_if.slave tw_if
);
  localparam int          KW = NLOG2 - 2 * STAGE;
  localparam int unsigned QN = FFT_N / 4;
  localparam int          AW = NLOG2 - 1;
  localparam int          RW = NLOG2 - 2;
  localparam int          TW = TWIDDLE_WIDTH;

  // ROM image is generated at elaboration with the same rounding as the hex image,
  // so TWIDDLE_FILE only names the equivalent external table.
  function automatic logic [(QN+1)*TW-1:0] build_cos_rom();
    logic [(QN+1)*TW-1:0] img;
    real x, term, acc, fs;
    img = '0;
    fs  = real'((1 << (TW - 1)) - 1);
    for (int unsigned i = 0; i <= QN; i++) begin
      x    = 2.0 * 3.14159265358979323846 * real'(i) / real'(FFT_N);
      term = 1.0;
      acc  = 1.0;
      for (int unsigned n = 1; n <= 16; n++) begin
        term = -term * x * x / real'((2 * n - 1) * (2 * n));
        acc  = acc + term;
      end
      img[i*TW +: TW] = TW'($rtoi(acc * fs + 0.5));
    end
    return img;
  endfunction

  localparam logic [(QN+1)*TW-1:0] COS_ROM = build_cos_rom();

  logic [KW-1:0]          k_q, k_d, idx;
  logic [NLOG2-1:0]       e_q, e_d, m;
  logic [NLOG2+1:0]       prod;
  logic [1:0]             q, mult;
  logic                   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [1:0]             quad_q, quad_d;
  logic [RW-1:0]          r;
  logic [AW-1:0]          a_cos, a_sin;
  logic signed [TW-1:0]   c_r_q, c_r_d, c_s_q, c_s_d;
  logic signed [TW-1:0]   w_re_q, w_re_d, w_im_q, w_im_d;

  // Counter and exponent mapping (feeds P1)
  always_comb begin
    idx = tw_if.sync_i ? '0 : k_q;
    k_d = k_q;
    if (tw_if.ce_i) begin
      k_d = idx + KW'(1);
    end else if (tw_if.sync_i) begin
      k_d = '0;
    end
    q = idx[KW-1 -: 2];
    m = NLOG2'(idx) & NLOG2'((FFT_N >> (2 * STAGE + 2)) - 1);
    case (q)
      2'd0:    mult = 2'd0;
      2'd1:    mult = 2'd2;
      2'd2:    mult = 2'd1;
      default: mult = 2'd3;
    endcase
    prod = (NLOG2+2)'(m) * (NLOG2+2)'(mult);
    e_d  = NLOG2'(prod << (2 * STAGE));
    v1_d = tw_if.ce_i;
  end

  // P2: both ROM reads for the exponent's quadrant-folded offset
  always_comb begin
    quad_d = e_q[NLOG2-1 -: 2];
    r      = e_q[RW-1:0];
    a_cos  = AW'(r);
    a_sin  = AW'(QN) - AW'(r);
    c_r_d  = COS_ROM[int'(a_cos)*TW +: TW];
    c_s_d  = COS_ROM[int'(a_sin)*TW +: TW];
    v2_d   = v1_q;
  end

  // P3: quadrant signs, W = cos - j*sin; hold outputs on empty slots
  always_comb begin
    w_re_d = w_re_q;
    w_im_d = w_im_q;
    if (v2_q) begin
      case (quad_q)
        2'd0: begin
          w_re_d = c_r_q;
          w_im_d = -c_s_q;
        end
        2'd1: begin
          w_re_d = -c_s_q;
          w_im_d = -c_r_q;
        end
        default: begin
          w_re_d = -c_r_q;
          w_im_d = c_s_q;
        end
      endcase
    end
    v3_d = v2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q    <= '0;
      e_q    <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      quad_q <= '0;
      c_r_q  <= '0;
      c_s_q  <= '0;
      w_re_q <= '0;
      w_im_q <= '0;
    end else begin
      k_q    <= k_d;
      e_q    <= e_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      quad_q <= quad_d;
      c_r_q  <= c_r_d;
      c_s_q  <= c_s_d;
      w_re_q <= w_re_d;
      w_im_q <= w_im_d;
    end
  end

  assign tw_if.w_re_o  = w_re_q;
  assign tw_if.w_im_o  = w_im_q;
  assign tw_if.valid_o = v3_q;
endmodule

// File: tb/tb_fft_twiddle_gen.sv
// Scoreboard bench: a 16-point STAGE=0 instance and a STAGE=1 instance on shared stimulus.
module tb_fft_twiddle_gen;
  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic signed [9:0] re;
    logic signed [9:0] im;
  } tw_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_twiddle_gen_if #(.TWIDDLE_WIDTH(10)) tw0 ();
  fft_twiddle_gen_if #(.TWIDDLE_WIDTH(10)) tw1 ();

  fft_twiddle_gen #(
    .TWIDDLE_WIDTH(10), .FFT_N(16), .NLOG2(4), .STAGE(0), .TWIDDLE_FILE("cos.hex")
  ) u_stage0 (
    .clk_i(clk), .rst_i(rst), .tw_if(tw0.slave)
  );

  fft_twiddle_gen #(
    .TWIDDLE_WIDTH(10), .FFT_N(16), .NLOG2(4), .STAGE(1), .TWIDDLE_FILE("cos.hex")
  ) u_stage1 (
    .clk_i(clk), .rst_i(rst), .tw_if(tw1.slave)
  );

  int   n_vec  = 0;
  int   n_miss = 0;
  tw_t  sb0[$];
  tw_t  sb1[$];
  tw_t  cur0, cur1;
  logic [2:0]  vp;
  int unsigned k0, k1;

  function automatic int rha(real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Expected W for sample index idx of a 16-point transform at stage stg.
  function automatic tw_t exp_tw(int unsigned idx, int unsigned stg);
    tw_t t;
    int unsigned quarter, qd, m, e;
    int unsigned mult [4];
    real a;
    mult    = '{0, 2, 1, 3};
    quarter = (16 >> (2 * stg)) / 4;
    qd      = idx / quarter;
    m       = idx % quarter;
    e       = (m * mult[qd]) << (2 * stg);
    a       = 2.0 * PI * real'(e) / 16.0;
    t.re    = 10'(rha($cos(a) * 511.0));
    t.im    = 10'(-rha($sin(a) * 511.0));
    return t;
  endfunction

  // One clock of stimulus; the model advances and pops the twiddle due this cycle.
  task automatic drive(input logic ce, input logic sync, input logic rs);
    int unsigned i0, i1;
    tw0.ce_i = ce; tw0.sync_i = sync;
    tw1.ce_i = ce; tw1.sync_i = sync;
    rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      k0 = 0; k1 = 0; vp = '0;
      sb0.delete(); sb1.delete();
      cur0 = '0; cur1 = '0;
    end else begin
      i0 = sync ? 0 : k0;
      i1 = sync ? 0 : k1;
      if (ce) begin
        sb0.push_back(exp_tw(i0, 0));
        sb1.push_back(exp_tw(i1, 1));
        k0 = (i0 + 1) % 16;
        k1 = (i1 + 1) % 4;
      end else if (sync) begin
        k0 = 0; k1 = 0;
      end
      vp = {vp[1:0], ce};
      if (vp[2] && sb0.size() != 0) cur0 = sb0.pop_front();
      if (vp[2] && sb1.size() != 0) cur1 = sb1.pop_front();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      n_vec++;
      if (tw0.valid_o !== 1'b0)
        begin n_miss++; $display("FAIL reset_valid i=%0d got %b want 0", i, tw0.valid_o); end
      n_vec++;
      if ({tw0.w_re_o, tw0.w_im_o} !== 20'd0)
        begin n_miss++; $display("FAIL reset_w i=%0d got (%0d,%0d) want (0,0)", i, tw0.w_re_o, tw0.w_im_o); end
    end
  endtask

  task automatic test_frames();
    for (int i = 0; i < 35; i++) begin
      drive(logic'(i < 32), logic'(i == 0), 1'b0);
      n_vec++;
      if (tw0.valid_o !== vp[2])
        begin n_miss++; $display("FAIL frames_valid i=%0d got %b want %b", i, tw0.valid_o, vp[2]); end
      n_vec++;
      if ({tw0.w_re_o, tw0.w_im_o} !== {cur0.re, cur0.im})
        begin n_miss++; $display("FAIL frames_w i=%0d got (%0d,%0d) want (%0d,%0d)", i, tw0.w_re_o, tw0.w_im_o, cur0.re, cur0.im); end
    end
  endtask

  task automatic test_gaps();
    logic [8:0] pat;
    pat = 9'b000_010101;
    for (int i = 0; i < 9; i++) begin
      drive(pat[i], 1'b0, 1'b0);
      n_vec++;
      if (tw0.valid_o !== vp[2])
        begin n_miss++; $display("FAIL gaps_valid i=%0d got %b want %b", i, tw0.valid_o, vp[2]); end
      n_vec++;
      if ({tw0.w_re_o, tw0.w_im_o} !== {cur0.re, cur0.im})
        begin n_miss++; $display("FAIL gaps_w i=%0d got (%0d,%0d) want (%0d,%0d)", i, tw0.w_re_o, tw0.w_im_o, cur0.re, cur0.im); end
    end
  endtask

  // Mid-frame resync at index 7, then a sync without ce that re-zeroes the counter.
  task automatic test_resync();
    for (int i = 0; i < 20; i++) begin
      drive(logic'(i < 14 || i == 15 || i == 16), logic'(i == 0 || i == 7 || i == 14), 1'b0);
      n_vec++;
      if (tw0.valid_o !== vp[2])
        begin n_miss++; $display("FAIL resync_valid i=%0d got %b want %b", i, tw0.valid_o, vp[2]); end
      n_vec++;
      if ({tw0.w_re_o, tw0.w_im_o} !== {cur0.re, cur0.im})
        begin n_miss++; $display("FAIL resync_w i=%0d got (%0d,%0d) want (%0d,%0d)", i, tw0.w_re_o, tw0.w_im_o, cur0.re, cur0.im); end
    end
  endtask

  task automatic test_reset_in_flight();
    logic [6:0] ce_pat, rs_pat;
    ce_pat = 7'b000_0111;
    rs_pat = 7'b000_0100;
    for (int i = 0; i < 7; i++) begin
      drive(ce_pat[i], logic'(i == 0), rs_pat[i]);
      n_vec++;
      if (tw0.valid_o !== vp[2])
        begin n_miss++; $display("FAIL flight_valid i=%0d got %b want %b", i, tw0.valid_o, vp[2]); end
      n_vec++;
      if ({tw0.w_re_o, tw0.w_im_o} !== {cur0.re, cur0.im})
        begin n_miss++; $display("FAIL flight_w i=%0d got (%0d,%0d) want (%0d,%0d)", i, tw0.w_re_o, tw0.w_im_o, cur0.re, cur0.im); end
    end
  endtask

  task automatic test_stage1();
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      drive(logic'(i < 8), 1'b0, 1'b0);
      n_vec++;
      if (tw1.valid_o !== vp[2])
        begin n_miss++; $display("FAIL stage1_valid i=%0d got %b want %b", i, tw1.valid_o, vp[2]); end
      n_vec++;
      if ({tw1.w_re_o, tw1.w_im_o} !== {cur1.re, cur1.im})
        begin n_miss++; $display("FAIL stage1_w i=%0d got (%0d,%0d) want (%0d,%0d)", i, tw1.w_re_o, tw1.w_im_o, cur1.re, cur1.im); end
      n_vec++;
      if ({tw0.w_re_o, tw0.w_im_o} !== {cur0.re, cur0.im})
        begin n_miss++; $display("FAIL stage1_s0_w i=%0d got (%0d,%0d) want (%0d,%0d)", i, tw0.w_re_o, tw0.w_im_o, cur0.re, cur0.im); end
    end
  endtask

  initial begin
    tw0.ce_i = 1'b0; tw0.sync_i = 1'b0;
    tw1.ce_i = 1'b0; tw1.sync_i = 1'b0;
    rst = 1'b1;
    vp = '0; k0 = 0; k1 = 0; cur0 = '0; cur1 = '0;
    test_reset();
    test_frames();
    test_gaps();
    test_resync();
    test_reset_in_flight();
    test_stage1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
